// File: rtl/unidade_controle_param.sv
// Game-flow controller for ultimate tic-tac-toe: macro/micro selection, validation, write-back,
// win check and turn hand-over, with internal validation delay, per-turn timeout and N players.
module unidade_controle_param #(
    parameter int VALIDA_CICLOS  = 4,
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int N_JOGADORES    = 2,
    parameter int MODO_TIMEOUT   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       macro_vencida,
    input  logic       micro_jogada,
    input  logic       fim_jogo,
    output logic       zeraR_macro,
    output logic       zeraR_micro,
    output logic       zeraEdge,
    output logic       registraR_macro,
    output logic       registraR_micro,
    output logic       sinal_macro,
    output logic       sinal_valida_macro,
    output logic       jogar_macro,
    output logic       jogar_micro,
    output logic       we_board,
    output logic       we_board_state,
    output logic       troca_jogador,
    output logic       estouro,
    output logic       fim_por_tempo,
    output logic       pronto,
    output logic [1:0] jogador,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL            = 4'h0,
        PREPARACAO         = 4'h1,
        JOGA_MACRO         = 4'h2,
        REGISTRA_MACRO     = 4'h3,
        VALIDA_MACRO       = 4'h4,
        JOGA_MICRO         = 4'h5,
        REGISTRA_MICRO     = 4'h6,
        VALIDA_MICRO       = 4'h7,
        REGISTRA_JOGADA    = 4'h8,
        VERIFICA_MACRO     = 4'h9,
        REGISTRA_RESULTADO = 4'hA,
        VERIFICA_TABULEIRO = 4'hB,
        TROCAR_JOGADOR     = 4'hC,
        DECIDE_MACRO       = 4'hD,
        ESTOURO_TEMPO      = 4'hE,
        FIM                = 4'hF
    } t_estado;

    localparam logic [15:0] VALIDA_FIM = 16'(VALIDA_CICLOS - 1);
    localparam logic [15:0] TEMPO_FIM  = 16'(TIMEOUT_CICLOS - 1);
    localparam logic [1:0]  ULTIMO     = 2'(N_JOGADORES - 1);

    t_estado     r_estado;
    t_estado     w_prox;
    logic [13:0] r_saidas;
    logic [15:0] r_cnt_valida;
    logic [15:0] r_cnt_turno;
    logic [1:0]  r_jogador;
    logic        r_fim_tempo;
    logic        w_valida_fim;
    logic        w_timeout;

    assign w_valida_fim = (r_cnt_valida == VALIDA_FIM);
    // tem_jogada wins over an expiring timer in the same cycle
    assign w_timeout    = (MODO_TIMEOUT != 0) && (r_cnt_turno == TEMPO_FIM) && !tem_jogada;

    // Output vector order: zeraR_macro, zeraR_micro, zeraEdge, registraR_macro, registraR_micro,
    // sinal_macro, sinal_valida_macro, jogar_macro, jogar_micro, we_board, we_board_state,
    // troca_jogador, estouro, pronto.
    function automatic logic [13:0] decodifica(input t_estado e);
        decodifica = {
            (e == INICIAL) || (e == PREPARACAO),
            (e == INICIAL) || (e == PREPARACAO) || (e == JOGA_MICRO),
            (e == INICIAL),
            (e == REGISTRA_MACRO) || (e == DECIDE_MACRO),
            (e == REGISTRA_MICRO),
            (e == JOGA_MACRO) || (e == REGISTRA_MACRO),
            (e == REGISTRA_MACRO) || (e == VALIDA_MACRO),
            (e == JOGA_MACRO),
            (e == JOGA_MICRO),
            (e == REGISTRA_JOGADA),
            (e == REGISTRA_RESULTADO),
            (e == TROCAR_JOGADOR),
            (e == ESTOURO_TEMPO),
            (e == FIM)
        };
    endfunction

    always_comb begin
        w_prox = INICIAL;
        case (r_estado)
            INICIAL:            w_prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:         w_prox = JOGA_MACRO;
            JOGA_MACRO: begin
                if (tem_jogada)     w_prox = REGISTRA_MACRO;
                else if (w_timeout) w_prox = ESTOURO_TEMPO;
                else                w_prox = JOGA_MACRO;
            end
            REGISTRA_MACRO:     w_prox = VALIDA_MACRO;
            VALIDA_MACRO: begin
                if (!w_valida_fim)      w_prox = VALIDA_MACRO;
                else if (macro_vencida) w_prox = PREPARACAO;
                else                    w_prox = JOGA_MICRO;
            end
            JOGA_MICRO: begin
                if (tem_jogada)     w_prox = REGISTRA_MICRO;
                else if (w_timeout) w_prox = ESTOURO_TEMPO;
                else                w_prox = JOGA_MICRO;
            end
            REGISTRA_MICRO:     w_prox = VALIDA_MICRO;
            VALIDA_MICRO: begin
                if (!w_valida_fim)     w_prox = VALIDA_MICRO;
                else if (micro_jogada) w_prox = JOGA_MICRO;
                else                   w_prox = REGISTRA_JOGADA;
            end
            REGISTRA_JOGADA:    w_prox = VERIFICA_MACRO;
            VERIFICA_MACRO:     w_prox = REGISTRA_RESULTADO;
            REGISTRA_RESULTADO: w_prox = VERIFICA_TABULEIRO;
            VERIFICA_TABULEIRO: w_prox = fim_jogo ? FIM : TROCAR_JOGADOR;
            TROCAR_JOGADOR:     w_prox = DECIDE_MACRO;
            DECIDE_MACRO:       w_prox = macro_vencida ? PREPARACAO : JOGA_MICRO;
            ESTOURO_TEMPO: begin
                if (MODO_TIMEOUT == 1)      w_prox = TROCAR_JOGADOR;
                else if (MODO_TIMEOUT == 2) w_prox = FIM;
                else                        w_prox = INICIAL;
            end
            FIM:                w_prox = iniciar ? INICIAL : FIM;
            default:            w_prox = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado     <= INICIAL;
            r_saidas     <= decodifica(INICIAL);
            r_cnt_valida <= 16'd0;
            r_cnt_turno  <= 16'd0;
            r_jogador    <= 2'd0;
            r_fim_tempo  <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_saidas <= decodifica(w_prox);

            case (r_estado)
                REGISTRA_MACRO, REGISTRA_MICRO: r_cnt_valida <= 16'd0;
                VALIDA_MACRO, VALIDA_MICRO:     r_cnt_valida <= r_cnt_valida + 16'd1;
                default:                        r_cnt_valida <= r_cnt_valida;
            endcase

            // Turn timer only runs while waiting for input; it survives re-picks.
            case (r_estado)
                INICIAL, TROCAR_JOGADOR: r_cnt_turno <= 16'd0;
                JOGA_MACRO, JOGA_MICRO:  r_cnt_turno <= r_cnt_turno + 16'd1;
                default:                 r_cnt_turno <= r_cnt_turno;
            endcase

            if (w_prox == INICIAL)
                r_jogador <= 2'd0;
            else if (r_estado == TROCAR_JOGADOR)
                r_jogador <= (r_jogador == ULTIMO) ? 2'd0 : r_jogador + 2'd1;

            if (w_prox == INICIAL)
                r_fim_tempo <= 1'b0;
            else if ((r_estado == ESTOURO_TEMPO) && (w_prox == FIM))
                r_fim_tempo <= 1'b1;
        end
    end

    assign {zeraR_macro, zeraR_micro, zeraEdge, registraR_macro, registraR_micro,
            sinal_macro, sinal_valida_macro, jogar_macro, jogar_micro, we_board,
            we_board_state, troca_jogador, estouro, pronto} = r_saidas;

    assign fim_por_tempo = r_fim_tempo;
    assign jogador       = r_jogador;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Bench for unidade_controle_param: three parameter sets driven by randomized turns; the expected
// state trace, outputs, player and timer are derived from the game rules cycle by cycle.
module tb_unidade_controle_param;

    localparam int VA [3] = '{4, 1, 2};
    localparam int TA [3] = '{20, 20, 3};
    localparam int NA [3] = '{3, 2, 2};
    localparam int MA [3] = '{1, 2, 0};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo;

    logic [13:0] o_vec [3];
    logic [3:0]  o_est [3];
    logic [1:0]  o_jog [3];
    logic        o_fpt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic zm, zu, ze, rm, ru, sm, svm, jm, ju, wb, wbs, tj, es, fpt, pr;
        logic [1:0] jog;
        logic [3:0] est;
        unidade_controle_param #(
            .VALIDA_CICLOS(VA[g]), .TIMEOUT_CICLOS(TA[g]),
            .N_JOGADORES(NA[g]), .MODO_TIMEOUT(MA[g])
        ) u_dut (
            .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
            .macro_vencida(macro_vencida), .micro_jogada(micro_jogada), .fim_jogo(fim_jogo),
            .zeraR_macro(zm), .zeraR_micro(zu), .zeraEdge(ze),
            .registraR_macro(rm), .registraR_micro(ru),
            .sinal_macro(sm), .sinal_valida_macro(svm),
            .jogar_macro(jm), .jogar_micro(ju),
            .we_board(wb), .we_board_state(wbs), .troca_jogador(tj), .estouro(es),
            .fim_por_tempo(fpt), .pronto(pr), .jogador(jog), .db_estado(est)
        );
        assign o_vec[g] = {zm, zu, ze, rm, ru, sm, svm, jm, ju, wb, wbs, tj, es, pr};
        assign o_est[g] = est;
        assign o_jog[g] = jog;
        assign o_fpt[g] = fpt;
    end

    int n_chk, n_fail;
    int sel;
    int m_jog, m_timer, where;   // where: 0 waiting macro, 1 waiting micro, 2 game over
    logic m_fpt;
    bit e;

    // Output table straight from the state-to-output list, same bit order as o_vec.
    function automatic logic [13:0] exp_vec(input int c);
        exp_vec = {c == 0 || c == 1, c == 0 || c == 1 || c == 5, c == 0, c == 3 || c == 13,
                   c == 6, c == 2 || c == 3, c == 3 || c == 4, c == 2, c == 5, c == 8,
                   c == 10, c == 12, c == 14, c == 15};
    endfunction

    function automatic bit choose(input int forced, input int prob);
        if (forced >= 0) return forced != 0;
        return ($urandom % 32'(prob)) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s dut=%0d observed=%0h expected=%0h t=%0t", tag, sel, obs, expv, $time);
        end
    endtask

    task automatic check_all(input int c);
        chk("estado", 32'(o_est[sel]), 32'(c));
        chk("saidas", 32'(o_vec[sel]), 32'(exp_vec(c)));
        chk("jogador", 32'(o_jog[sel]), 32'(m_jog));
        chk("fim_por_tempo", 32'(o_fpt[sel]), 32'(m_fpt));
    endtask

    task automatic tick(input int c);
        @(posedge clock);
        #1;
        check_all(c);
    endtask

    task automatic troca(input int fmv);
        bit mv;
        tick(12);
        m_jog   = (m_jog + 1) % NA[sel];
        m_timer = 0;
        tick(13);
        mv = choose(fmv, 3);
        macro_vencida = mv;
        if (mv) begin tick(1); tick(2); where = 0; end
        else    begin tick(5); where = 1; end
    endtask

    // Idle in the current joga state for up to n cycles; the turn timer may expire.
    task automatic idle(input int n, output bit ended);
        ended = 0;
        for (int i = 0; i < n; i++) begin
            if (MA[sel] != 0 && m_timer == TA[sel] - 1) begin
                iniciar = 1'b0;
                tick(14);
                ended = 1;
                if (MA[sel] == 1) troca(-1);
                else begin m_fpt = 1'b1; tick(15); where = 2; end
                break;
            end
            iniciar = 1'($urandom % 2);
            tick(where == 0 ? 2 : 5);
            m_timer++;
        end
        iniciar = 1'b0;
    endtask

    task automatic pick_macro(input int fmv);
        bit mv;
        mv = choose(fmv, 4);
        macro_vencida = mv;
        tem_jogada = 1'b1;
        tick(3);
        tem_jogada = 1'b0;
        m_timer++;
        repeat (VA[sel]) tick(4);
        if (mv) begin tick(1); tick(2); where = 0; end
        else    begin tick(5); where = 1; end
    endtask

    task automatic pick_micro(input int fmj, input int ffj, input int fmv);
        bit mj, fj;
        mj = choose(fmj, 4);
        micro_jogada = mj;
        tem_jogada = 1'b1;
        tick(6);
        tem_jogada = 1'b0;
        m_timer++;
        repeat (VA[sel]) tick(7);
        if (mj) begin
            tick(5);
            where = 1;
        end else begin
            tick(8); tick(9); tick(10);
            fj = choose(ffj, 6);
            fim_jogo = fj;
            tick(11);
            if (fj) begin tick(15); where = 2; fim_jogo = 1'b0; end
            else troca(fmv);
        end
    endtask

    task automatic play(input int turns);
        bit ended;
        int n;
        for (int t = 0; t < turns && where != 2; t++) begin
            n = choose(-1, 5) ? int'($urandom_range(25, 10)) : int'($urandom_range(6, 0));
            idle(n, ended);
            if (!ended) begin
                if (where == 0) pick_macro(-1);
                else            pick_micro(-1, -1, -1);
            end
        end
    endtask

    task automatic start(input int s);
        sel = s;
        iniciar = 0; tem_jogada = 0; macro_vencida = 0; micro_jogada = 0; fim_jogo = 0;
        @(posedge clock);
        #1 reset = 1'b1;
        #2;
        m_jog = 0; m_timer = 0; m_fpt = 1'b0;
        check_all(0);
        reset = 1'b0;
        tick(0);
        iniciar = 1'b1; tick(1);
        iniciar = 1'b0; tick(2);
        where = 0;
    endtask

    task automatic restart_from_fim();
        tick(15); tick(15);
        iniciar = 1'b1;
        m_jog = 0; m_timer = 0; m_fpt = 1'b0;
        tick(0);
        tick(1);
        iniciar = 1'b0;
        tick(2);
        where = 0;
    endtask

    initial begin
        reset = 1'b1; iniciar = 0; tem_jogada = 0; macro_vencida = 0; micro_jogada = 0;
        fim_jogo = 0; n_chk = 0; n_fail = 0; sel = 0; where = 0;
        m_jog = 0; m_timer = 0; m_fpt = 1'b0;

        // Timeout-skips-turn, three players, four-cycle validation.
        start(0);
        idle(19, e);                 // 20th joga cycle carries the pick: no timeout
        pick_macro(0);
        idle(2, e);
        pick_micro(1, -1, -1);       // occupied micro: back to joga_micro, no write
        pick_micro(0, 0, 0);         // full turn, player 0 -> 1
        idle(25, e);                 // timer expires after 20 joga cycles
        play(40);
        if (where == 2) restart_from_fim();
        if (where == 0) pick_macro(0);
        micro_jogada = 1'b0;
        tem_jogada = 1'b1;
        tick(6);
        tem_jogada = 1'b0;
        tick(7);
        reset = 1'b1;                // asynchronous reset in the middle of valida_micro
        #2;
        m_jog = 0; m_timer = 0; m_fpt = 1'b0;
        check_all(0);
        reset = 1'b0;
        tick(0); tick(0);

        // Timeout-ends-game, single-cycle validation.
        start(1);
        for (int g = 0; g < 3; g++) begin
            play(20);
            if (where != 2) idle(30, e);
            restart_from_fim();
        end

        // Timeout disabled with a tiny timer limit.
        start(2);
        idle(40, e);
        play(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle_param.md
# unidade_controle_param

Parametrised game-flow controller for the ultimate tic-tac-toe datapath: it sequences macro-cell selection, micro-cell selection, validation, board write-back, win check and turn hand-over. It adds three things to the fixed-function flow. Validation delay is counted internally rather than through an external `fimT`. Each turn has a per-turn move timeout with a selectable policy. Player count is configurable, with an internal player index. It sits between the edge-detected button inputs and the board/register datapath.

## Interface
- VALIDA_CICLOS, 4, cycles spent in each validation state (1..65535)
- TIMEOUT_CICLOS, 1000, max cycles in joga states per turn before timeout (2..65535)
- N_JOGADORES, 2, number of players, index wraps at N_JOGADORES-1 (2..4)
- MODO_TIMEOUT, 1, 0 = no timeout, 1 = timeout skips turn, 2 = timeout ends game
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces `inicial`, clears counters and flags
- iniciar  in  1  start / restart request
- tem_jogada  in  1  move-button pulse from edge detector
- macro_vencida  in  1  selected macro cell already decided
- micro_jogada  in  1  selected micro cell already occupied
- fim_jogo  in  1  board-level game over
- zeraR_macro, zeraR_micro, zeraEdge  out  1 each  datapath clears
- registraR_macro, registraR_micro  out  1 each  register loads
- sinal_macro, sinal_valida_macro  out  1 each  datapath mux selects
- jogar_macro, jogar_micro  out  1 each  waiting-for-input indicators
- we_board, we_board_state  out  1 each  board / board-state RAM write enables
- troca_jogador  out  1  one-cycle turn hand-over pulse
- estouro  out  1  one-cycle timeout pulse
- fim_por_tempo  out  1  game ended by timeout (held)
- pronto  out  1  game finished
- jogador  out  2  current player index
- db_estado  out  4  current state code

## Operation
- Moore FSM. States and codes:
  - inicial 0, preparacao 1, joga_macro 2, registra_macro 3, valida_macro 4, joga_micro 5, registra_micro 6
  - valida_micro 7, registra_jogada 8, verifica_macro 9, registra_resultado A, verifica_tabuleiro B
  - trocar_jogador C, decide_macro D, estouro_tempo E, fim F
- Transitions:
  - inicial → preparacao if iniciar.
  - preparacao → joga_macro.
  - joga_macro → registra_macro if tem_jogada. Otherwise → estouro_tempo on timeout.
  - registra_macro → valida_macro.
  - valida_macro exits on its last cycle: → preparacao if macro_vencida, else → joga_micro.
  - joga_micro → registra_micro if tem_jogada. Otherwise → estouro_tempo on timeout.
  - registra_micro → valida_micro.
  - valida_micro exits on its last cycle: → joga_micro if micro_jogada, else → registra_jogada.
  - registra_jogada → verifica_macro → registra_resultado → verifica_tabuleiro.
  - verifica_tabuleiro → fim if fim_jogo, else → trocar_jogador.
  - trocar_jogador → decide_macro.
  - decide_macro → preparacao if macro_vencida, else → joga_micro.
  - estouro_tempo → trocar_jogador if MODO_TIMEOUT=1, → fim if MODO_TIMEOUT=2.
  - fim → inicial if iniciar.
- Validation counter (16 bit):
  - Zeroed in registra_macro and registra_micro.
  - Increments in valida states.
  - A valida state lasts exactly VALIDA_CICLOS cycles; exit when counter = VALIDA_CICLOS-1.
- Turn timer (16 bit):
  - Zeroed in inicial and trocar_jogador.
  - Increments only in joga_macro and joga_micro; holds elsewhere, including across re-picks.
  - Timeout = timer equals TIMEOUT_CICLOS-1 while in a joga state with tem_jogada=0.
  - tem_jogada has priority over timeout in the same cycle.
  - MODO_TIMEOUT=0: timer never triggers, and estouro_tempo is unreachable.
- Player index:
  - 0 in inicial.
  - Increments in trocar_jogador; N_JOGADORES-1 wraps to 0.
- fim_por_tempo:
  - Set on the cycle estouro_tempo transitions to fim (MODO_TIMEOUT=2).
  - Cleared in inicial and by reset.
- Output decode:
  - zeraR_macro: inicial, preparacao.
  - zeraR_micro: inicial, preparacao, joga_micro.
  - zeraEdge: inicial.
  - registraR_macro: registra_macro, decide_macro.
  - registraR_micro: registra_micro.
  - sinal_macro: joga_macro, registra_macro.
  - sinal_valida_macro: registra_macro, valida_macro.
  - jogar_macro / jogar_micro: their joga state.
  - we_board: registra_jogada.
  - we_board_state: registra_resultado.
  - troca_jogador: trocar_jogador.
  - estouro: estouro_tempo.
  - pronto: fim.
  - db_estado: state code.
- iniciar is ignored outside inicial and fim. Unreachable or illegal codes go → inicial.

## Timing
- Reset values:
  - FSM in inicial, so zeraR_macro=1, zeraR_micro=1, zeraEdge=1.
  - All other single-bit outputs 0; jogador=0; db_estado=0; both counters 0.
- Reset mid-game: immediate return to inicial with the values above; no pending write survives.
- iniciar high at edge k (in inicial): preparacao at k+1, joga_macro at k+2.
- Valid macro pick, tem_jogada at edge k:
  - registra_macro at k+1.
  - valida_macro for cycles k+2 .. k+1+VALIDA_CICLOS.
  - joga_micro at k+2+VALIDA_CICLOS.
- Valid micro pick, tem_jogada at edge k:
  - we_board at k+2+VALIDA_CICLOS.
  - we_board_state two cycles later.
  - troca_jogador four cycles later when the game is not over.
- Write-enable and pulse outputs (we_board, we_board_state, troca_jogador, estouro) are exactly one cycle wide.

## Test plan
- Reset, then iniciar at cycle 2 → db_estado 0,1,2 on cycles 2,3,4; jogador=0; zeraEdge=1 only in state 0.
- VALIDA_CICLOS=4: macro pick with macro_vencida=0, then micro pick with micro_jogada=0 and fim_jogo=0 → valida states last 4 cycles each; we_board, we_board_state and troca_jogador pulse once each; jogador 0→1.
- macro_vencida=1 at end of valida_macro → preparacao, player unchanged. micro_jogada=1 → back to joga_micro with no we_board.
- N_JOGADORES=3: three complete turns → jogador 0,1,2,0.
- TIMEOUT_CICLOS=20, MODO_TIMEOUT=1, no input → estouro pulses in state E after 20 joga cycles, then troca_jogador; tem_jogada on cycle 20 instead → registra_macro, no estouro.
- MODO_TIMEOUT=2 timeout → fim, pronto=1, fim_por_tempo=1; iniciar → inicial, fim_por_tempo=0. Assert reset during valida_micro → state 0 next, no we_board.
